// File: rtl/d7s_pkg.sv
// Shared 7-segment definitions for the display driver and the capture monitor.
// Keeping the encode and decode tables in one place stops them from drifting apart.
package d7s_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } seg_dec_t;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_kind_e;

endpackage

// File: rtl/d7s_seg_decode.sv
// Combinational inverse of the segment encoder: pattern -> {legal, value}.
// Anything outside the sixteen hex glyphs, including blank, is flagged illegal.
module d7s_seg_decode
  import d7s_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o.legal = 1'b1;
    dec_o.value = 4'h0;
    case (seg_i)
      SEG_HEX_0: dec_o.value = 4'h0;
      SEG_HEX_1: dec_o.value = 4'h1;
      SEG_HEX_2: dec_o.value = 4'h2;
      SEG_HEX_3: dec_o.value = 4'h3;
      SEG_HEX_4: dec_o.value = 4'h4;
      SEG_HEX_5: dec_o.value = 4'h5;
      SEG_HEX_6: dec_o.value = 4'h6;
      SEG_HEX_7: dec_o.value = 4'h7;
      SEG_HEX_8: dec_o.value = 4'h8;
      SEG_HEX_9: dec_o.value = 4'h9;
      SEG_HEX_A: dec_o.value = 4'hA;
      SEG_HEX_B: dec_o.value = 4'hB;
      SEG_HEX_C: dec_o.value = 4'hC;
      SEG_HEX_D: dec_o.value = 4'hD;
      SEG_HEX_E: dec_o.value = 4'hE;
      SEG_HEX_F: dec_o.value = 4'hF;
      default:   dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/d7s_capture.sv
// Receive-side monitor for a multiplexed 7-segment bus: synchronizes, waits for a
// stable window, demultiplexes by digit select and decodes each digit back to hex.
module d7s_capture
  import d7s_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   sel_in,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]           sync1_q, sync2_q;
  logic [CW-1:0]           stableCnt_q, stableCnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seenBase;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic                    inStable;
  logic                    strobe;
  logic [6:0]              segLvl;
  logic [NUM_DIGITS-1:0]   selLvl;
  sel_kind_e               selKind;
  seg_dec_t                segDec;

  assign segLvl = sync2_q[6:0] ^ {7{SEG_ACTIVE_LOW}};
  assign selLvl = sync2_q[SW-1:7] ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};

  d7s_seg_decode u_decode (
    .seg_i (segLvl),
    .dec_o (segDec)
  );

  // The counter compares the value about to enter s2 with s2 itself, so stableCnt_q
  // already reflects whether s2 matches its predecessor in the current cycle.
  always_comb begin
    inStable    = (sync1_q == sync2_q);
    stableCnt_d = '0;
    if (inStable) begin
      stableCnt_d = (stableCnt_q == CNT_MAX) ? CNT_MAX : stableCnt_q + CW'(1);
    end
    strobe = inStable && (stableCnt_q == CNT_ARM);
  end

  always_comb begin
    selKind = SEL_MULTI;
    if (selLvl == '0) begin
      selKind = SEL_NONE;
    end else if ((selLvl & (selLvl - NUM_DIGITS'(1))) == '0) begin
      selKind = SEL_ONE;
    end
  end

  // A full mask is reported on the following cycle and cleared on that same edge.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    frame_d  = 1'b0;
    seenBase = (&seen_q) ? '0 : seen_q;
    seen_d   = seenBase;
    if (clr) begin
      valid_d = '0;
      err_d   = 1'b0;
      seen_d  = '0;
    end else begin
      frame_d = &seen_q;
      if (strobe && (selKind == SEL_MULTI)) begin
        err_d = 1'b1;
      end else if (strobe && (selKind == SEL_ONE)) begin
        seen_d = seenBase | selLvl;
        if (!segDec.legal) begin
          err_d = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (selLvl[i]) begin
            valid_d[i] = segDec.legal;
            if (segDec.legal) begin
              digits_d[4*i +: 4] = segDec.value;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stableCnt_q <= '0;
      digits_q    <= '0;
      valid_q     <= '0;
      seen_q      <= '0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= {sel_in, seg_in};
      sync2_q     <= sync1_q;
      stableCnt_q <= stableCnt_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign err         = err_q;

endmodule

// File: doc/d7s_capture.md
# d7s_capture

Receive-side counterpart of the multiplexed 7-segment driver. Samples the segment lines and digit-select lines as driven toward the display and demultiplexes them. Decodes each digit's segment pattern back to a 4-bit hex value and reports per-digit validity, frame completion and protocol errors. Used as an on-chip loopback monitor and as a capture block for an externally driven display bus.

## Interface
- NUM_DIGITS, 3: number of multiplexed digits and width of the select bus; legal range 1..8.
- STABLE_CYCLES, 4: consecutive cycles the synchronized {sel, seg} must be unchanged before a capture; must be ≥1.
- SEG_ACTIVE_LOW, 0: 1 means segment lines are active-low; they are inverted before decode.
- SEL_ACTIVE_LOW, 0: 1 means select lines are active-low; they are inverted before use.

- clk  input  1  single clock for all state.
- rst_n  input  1  reset, asynchronous and active-low.
- seg_in  input  7  segment lines, bit0=a … bit6=g (gfedcba).
- sel_in  input  NUM_DIGITS  digit select lines, one-hot when a digit is lit; bit i means digit i.
- clr  input  1  synchronous clear of err, digit_valid and the frame mask.
- digits_out  output  4*NUM_DIGITS  last legally decoded value per digit; digit i occupies [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i=1 when the most recent capture of digit i decoded legally.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse, clr or reset.
- err  output  1  sticky flag set by an illegal pattern or a multi-hot select.

## Operation
- Input conditioning:
  - seg_in and sel_in pass through a 2-flop synchronizer; call the second-stage output s2.
  - Polarity inversion per the parameters is applied after the synchronizer.
- Stability counter:
  - A register prev holds s2 from the previous cycle.
  - If s2 ≠ prev, count is set to 0. Otherwise count increments and saturates at STABLE_CYCLES.
  - A capture strobe fires on exactly the cycle count goes from STABLE_CYCLES-1 to STABLE_CYCLES. This gives one capture per stable period.
- On a capture strobe, the select value determines the action:
  - **sel all-zero** (blanking interval): no capture, no error.
  - **sel multi-hot**: err set; no digit state changes.
  - **sel one-hot, index i, legal pattern**: digits_out[i] updated; digit_valid[i]=1; seen[i]=1.
  - **sel one-hot, index i, illegal pattern** (includes blank 0x00): digits_out[i] held; digit_valid[i]=0; err set; seen[i]=1.
- Legal patterns (gfedcba hex → value): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. Every other code is illegal.
- Frame tracking:
  - seen is a NUM_DIGITS mask. Repeat captures of the same digit count once.
  - When the updated mask would be all ones, frame_done pulses on the next cycle and seen clears to 0 on that same edge.
- clr: clears err, digit_valid and seen. digits_out is held. clr has priority: a capture strobe in the same cycle is discarded entirely.

## Timing
- Reset values:
  - digits_out=0, digit_valid=0, frame_done=0, err=0.
  - Synchronizers, prev, count and seen are all 0.
- Latency: inputs first sampled stable at edge N → capture registered (digits_out/digit_valid/err updated) at edge N+1+STABLE_CYCLES. With defaults this is 5 edges after first sample.
- frame_done asserts at the edge after the completing capture, for exactly one cycle.
- Any input change during the stability window restarts the window. No partial captures occur.
- Holding inputs constant for many cycles produces one capture only. A new capture needs a change followed by a new stable window.
- Reset asserted mid-window or mid-frame: all state clears immediately (asynchronous). Capture resumes only after a full new stability window after release.
- err stays set until clr or reset; new errors while set have no further effect.

## Structure
- Package d7s_pkg holds:
  - segment bit-order constants (SEG_A..SEG_G);
  - the 16 pattern constants SEG_HEX_0..SEG_HEX_F;
  - SEG_BLANK.
  The driver side shares this package so the encode and decode tables cannot diverge.
- Sub-module d7s_seg_decode: purely combinational, 7-bit pattern → {legal, value[3:0]}.
- Top d7s_capture holds the synchronizer, stability counter, select check, per-digit registers and frame mask.

## Test plan
- Reset, then sel=001, seg=0x06 held 10 cycles → digits_out[3:0]=1 and digit_valid=001 at the 5th edge after first sample; exactly one capture; err=0.
- Sweep digits 0..2 with patterns 0x3F, 0x5B, 0x71, each held 6 cycles with sel=000 gaps → digits_out=0xF20, digit_valid=111, frame_done one-cycle pulse after the third capture, seen cleared.
- sel=010, seg=0x00 held 6 cycles → err=1, digit_valid[1]=0, digits_out[1] unchanged. Then sel=011 → no digit change, err remains 1. Then pulse clr → err=0, digit_valid=000.
- Glitch: sel=100, seg toggling 0x4F/0x66 every 2 cycles for 20 cycles → no capture. Then hold 0x66 → digits_out[11:8]=4 after full latency.
- Reset asserted 2 cycles into a stable window on digit 0 → all outputs 0 immediately. After release the same input captures only after a full new window.
- clr asserted on the exact capture cycle of a legal pattern → capture discarded; digit_valid, err and seen all 0.
